saq_drain: RTL and testbench



---
 rtl/saq_drain_pkg.sv | 31 +++
 rtl/saq_drain_commit_cnt.sv | 37 +++
 rtl/saq_drain.sv | 140 ++++++++++++++
 tb/tb_saq_drain.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saq_drain_pkg.sv
// Shared AGU definitions: store-queue entry field offsets and the drain FSM encoding.
package saq_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_POP  = 2'd2
  } state_e;

  // Entry layout, LSB first: tag, D, V, addr, val, A.
  function automatic int pos_d(input int wt);
    return wt;
  endfunction

  function automatic int pos_v(input int wt);
    return wt + 1;
  endfunction

  function automatic int pos_addr(input int wt);
    return wt + 2;
  endfunction

  function automatic int pos_val(input int wa, input int wt);
    return wt + 2 + wa;
  endfunction

  function automatic int pos_a(input int wa, input int wt);
    return wt + 3 + wa;
  endfunction

endpackage

// File: rtl/saq_drain_commit_cnt.sv
// Saturating up/down count of ROB-committed stores not yet drained.
module commit_cnt #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 2**WIDTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nz
);

  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(SIZE);

  logic [WIDTH:0] cnt_q, cnt_d;

  // A simultaneous inc and dec nets to zero; an inc at MAX is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && !i_dec && cnt_q != MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else if (i_dec && !i_inc && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_nz = (cnt_q != '0);

endmodule

// File: rtl/saq_drain.sv
// Store-queue drain: waits for ROB commit of the head store, issues one memory write, then pops.
module saq_drain
  import saq_drain_pkg::*;
#(
  parameter int WIDTH_TAG  = 5,
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH      = 4,
  parameter int SIZE       = 2**WIDTH,
  parameter int WIDTH_DATA = 4 + WIDTH_ADDR + WIDTH_TAG,
  parameter int WIDTH_WORD = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH_DATA-1:0] i_entry,
  input  logic                  i_empty,
  input  logic [WIDTH_WORD-1:0] i_data,
  input  logic [3:0]            i_strb,
  input  logic                  i_commit,
  output logic                  o_re,
  output logic                  o_mreq,
  output logic [WIDTH_ADDR-1:0] o_maddr,
  output logic [WIDTH_WORD-1:0] o_mdata,
  output logic [3:0]            o_mstrb,
  input  logic                  i_mack,
  output logic                  o_done,
  output logic [WIDTH_TAG-1:0]  o_done_tag
);

  localparam int P_D    = pos_d(WIDTH_TAG);
  localparam int P_V    = pos_v(WIDTH_TAG);
  localparam int P_ADDR = pos_addr(WIDTH_TAG);
  localparam int P_VAL  = pos_val(WIDTH_ADDR, WIDTH_TAG);
  localparam int P_A    = pos_a(WIDTH_ADDR, WIDTH_TAG);

  logic                  ent_a, ent_val, ent_v, ent_d;
  logic [WIDTH_ADDR-1:0] ent_addr;
  logic [WIDTH_TAG-1:0]  ent_tag;

  assign ent_a    = i_entry[P_A];
  assign ent_val  = i_entry[P_VAL];
  assign ent_addr = i_entry[P_ADDR +: WIDTH_ADDR];
  assign ent_v    = i_entry[P_V];
  assign ent_d    = i_entry[P_D];
  assign ent_tag  = i_entry[WIDTH_TAG-1:0];

  state_e state_q, state_d;
  logic   drop_q, drop_d;
  logic   eligible, launch, cnt_nz;

  logic [WIDTH_ADDR-1:0] maddr_q, maddr_d;
  logic [WIDTH_WORD-1:0] mdata_q, mdata_d;
  logic [3:0]            mstrb_q, mstrb_d;
  logic [WIDTH_TAG-1:0]  done_tag_q, done_tag_d;

  assign eligible = !i_empty && ent_a;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Head is sampled only in IDLE; squashed entries skip straight to POP.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          if (!ent_val) begin
            state_d = ST_POP;
            drop_d  = 1'b1;
          end else if (cnt_nz && ent_v && ent_d) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
            launch  = 1'b1;
          end
        end
      end
      ST_REQ:  if (i_mack) state_d = ST_POP;
      ST_POP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_re   = (state_q == ST_POP);
    o_mreq = (state_q == ST_REQ);
    o_done = (state_q == ST_POP) && !drop_q;
  end

  always_comb begin
    maddr_d    = maddr_q;
    mdata_d    = mdata_q;
    mstrb_d    = mstrb_q;
    done_tag_d = done_tag_q;
    if (launch) begin
      maddr_d    = ent_addr;
      mdata_d    = i_data;
      mstrb_d    = i_strb;
      done_tag_d = ent_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      maddr_q    <= '0;
      mdata_q    <= '0;
      mstrb_q    <= '0;
      done_tag_q <= '0;
    end else begin
      maddr_q    <= maddr_d;
      mdata_q    <= mdata_d;
      mstrb_q    <= mstrb_d;
      done_tag_q <= done_tag_d;
    end
  end

  assign o_maddr    = maddr_q;
  assign o_mdata    = mdata_q;
  assign o_mstrb    = mstrb_q;
  assign o_done_tag = done_tag_q;

  commit_cnt #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (i_commit),
    .i_dec   (o_done),
    .o_nz    (cnt_nz)
  );

endmodule

// File: tb/tb_saq_drain.sv
// Scoreboard bench for saq_drain: a queue model drives the head, a monitor checks requests and drains.
module tb_saq_drain;
  import saq_drain_pkg::*;

  localparam int WT = 5;
  localparam int WA = 32;
  localparam int SZ = 16;
  localparam int WD = 4 + WA + WT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WD-1:0] i_entry = '0;
  logic          i_empty = 1'b1;
  logic [31:0]   i_data = '0;
  logic [3:0]    i_strb = '0;
  logic          i_commit = 1'b0;
  logic          i_mack = 1'b0;
  logic          o_re, o_mreq, o_done;
  logic [WA-1:0] o_maddr;
  logic [31:0]   o_mdata;
  logic [3:0]    o_mstrb;
  logic [WT-1:0] o_done_tag;

  saq_drain dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_entry    (i_entry),
    .i_empty    (i_empty),
    .i_data     (i_data),
    .i_strb     (i_strb),
    .i_commit   (i_commit),
    .o_re       (o_re),
    .o_mreq     (o_mreq),
    .o_maddr    (o_maddr),
    .o_mdata    (o_mdata),
    .o_mstrb    (o_mstrb),
    .i_mack     (i_mack),
    .o_done     (o_done),
    .o_done_tag (o_done_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          a;
    logic          val;
    logic          v;
    logic          d;
    logic [WA-1:0] addr;
    logic [WT-1:0] tag;
    logic [31:0]   data;
    logic [3:0]    strb;
  } ent_t;

  ent_t          sq[$];
  ent_t          exp_req[$];
  logic [WT-1:0] exp_tag[$];

  int errors = 0, checks = 0;
  int credit = 0, uncommitted = 0;
  int cyc = 0, commit_cyc = 0, req_start = 0, mreq_run = 0, mreq_len = 0;
  int req_count = 0, pop_count = 0, done_count = 0;
  bit mon_en = 0, do_pop = 0, prev_mreq = 0, launch_ok = 0;
  logic [WA-1:0] p_maddr;
  logic [31:0]   p_mdata;
  logic [3:0]    p_mstrb;
  logic [WT-1:0] tag_ctr = 5'd16;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic a, input logic val, input logic [WA-1:0] addr,
                              input logic d, input logic [WT-1:0] tag,
                              input logic [31:0] data, input logic [3:0] strb);
    ent_t e;
    e.a = a; e.val = val; e.v = 1'b1; e.d = d; e.addr = addr; e.tag = tag;
    e.data = data; e.strb = strb;
    return e;
  endfunction

  task automatic drive_head();
    if (sq.size() == 0) begin
      i_empty = 1'b1; i_entry = '0; i_data = '0; i_strb = '0;
    end else begin
      i_empty = 1'b0;
      i_entry = {sq[0].a, sq[0].val, sq[0].addr, sq[0].v, sq[0].d, sq[0].tag};
      i_data  = sq[0].data;
      i_strb  = sq[0].strb;
    end
  endtask

  task automatic push(input ent_t e);
    sq.push_back(e);
    if (e.val) begin
      exp_req.push_back(e);
      exp_tag.push_back(e.tag);
      uncommitted++;
    end
    drive_head();
  endtask

  task automatic step(input bit commit, input bit mack);
    i_commit = commit;
    i_mack   = mack;
    if (commit) uncommitted--;
    @(posedge clk); #1;
    if (do_pop) begin
      do_pop = 0;
      if (sq.size() > 0) void'(sq.pop_front());
    end
    i_commit = 1'b0;
    drive_head();
  endtask

  // Monitor: compares DUT outputs against the queue model each cycle.
  always @(negedge clk) begin
    ent_t e;
    if (!mon_en) begin
      prev_mreq = 0;
      mreq_run  = 0;
    end else begin
      cyc++;
      chk("cnt", 64'(dut.u_cnt.cnt_q), 64'(credit));
      if (i_commit) commit_cyc = cyc;
      if (o_mreq && !prev_mreq) begin
        req_count++;
        req_start = cyc;
        chk("launch_allowed", 64'(launch_ok), 64'd1);
        if (exp_req.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
        else begin
          e = exp_req.pop_front();
          chk("maddr", 64'(o_maddr), 64'(e.addr));
          chk("mdata", 64'(o_mdata), 64'(e.data));
          chk("mstrb", 64'(o_mstrb), 64'(e.strb));
        end
      end
      if (o_mreq && prev_mreq) begin
        chk("maddr_stable", 64'(o_maddr), 64'(p_maddr));
        chk("mdata_stable", 64'(o_mdata), 64'(p_mdata));
        chk("mstrb_stable", 64'(o_mstrb), 64'(p_mstrb));
      end
      if (o_mreq) mreq_run++;
      else if (prev_mreq) begin
        mreq_len = mreq_run;
        mreq_run = 0;
      end
      if (o_re) begin
        pop_count++;
        if (sq.size() == 0) chk("pop_of_empty", 64'd1, 64'd0);
        else begin
          chk("pop_empty_flag", 64'(i_empty), 64'd0);
          chk("done_on_pop", 64'(o_done), 64'(sq[0].val));
          if (sq[0].val) begin
            done_count++;
            if (exp_tag.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else chk("done_tag", 64'(o_done_tag), 64'(exp_tag.pop_front()));
          end
          do_pop = 1;
        end
      end else begin
        chk("done_outside_pop", 64'(o_done), 64'd0);
      end
      launch_ok = (credit > 0) && (sq.size() > 0) && sq[0].a && sq[0].val && sq[0].v && sq[0].d;
      if (i_commit && !o_done) credit = (credit < SZ) ? credit + 1 : credit;
      else if (o_done && !i_commit) credit = credit - 1;
      prev_mreq = o_mreq;
      p_maddr = o_maddr; p_mdata = o_mdata; p_mstrb = o_mstrb;
    end
  end

  initial begin
    int r0, p0, d0, dset, c_before;
    bit did;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_re", 64'(o_re), 64'd0);
    chk("rst_mreq", 64'(o_mreq), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_maddr", 64'(o_maddr), 64'd0);
    chk("rst_mdata", 64'(o_mdata), 64'd0);
    chk("rst_mstrb", 64'(o_mstrb), 64'd0);
    chk("rst_done_tag", 64'(o_done_tag), 64'd0);
    chk("rst_cnt", 64'(dut.u_cnt.cnt_q), 64'd0);
    rst_n = 1'b1;
    mon_en = 1;
    step(0, 0);

    // Single committed store, immediate ack.
    push(mk(1, 1, 32'h100, 1, 5'd3, 32'hDEADBEEF, 4'hF));
    step(1, 1);
    repeat (5) step(0, 1);
    chk("t1_req_latency", 64'(req_start), 64'(commit_cyc + 2));
    chk("t1_req_len", 64'(mreq_len), 64'd1);
    chk("t1_done_tag", 64'(o_done_tag), 64'd3);
    chk("t1_cnt_zero", 64'(dut.u_cnt.cnt_q), 64'd0);

    // Valid head with no commit stalls.
    r0 = req_count;
    push(mk(1, 1, 32'h200, 1, 5'd4, 32'h12345678, 4'h3));
    repeat (10) step(0, 1);
    chk("t2_no_req_uncommitted", 64'(req_count), 64'(r0));
    step(1, 1);
    repeat (4) step(0, 1);
    chk("t2_req_after_commit", 64'(req_start), 64'(commit_cyc + 2));

    // D=0 stalls; held-off ack keeps request stable.
    r0 = req_count;
    push(mk(1, 1, 32'h300, 0, 5'd5, 32'hCAFEF00D, 4'h5));
    step(1, 0);
    repeat (5) step(0, 0);
    chk("t3_no_req_d0", 64'(req_count), 64'(r0));
    sq[0].d = 1'b1;
    drive_head();
    dset = cyc + 1;
    step(0, 0);
    repeat (5) step(0, 0);
    step(0, 1);
    repeat (2) step(0, 1);
    chk("t3_req_after_d", 64'(req_start), 64'(dset + 1));
    chk("t3_req_len", 64'(mreq_len), 64'd6);

    // Squashed head, then valid tag 7.
    p0 = pop_count; d0 = done_count;
    push(mk(1, 0, 32'h400, 1, 5'd9, 32'h0, 4'h0));
    push(mk(1, 1, 32'h500, 1, 5'd7, 32'hA5A5A5A5, 4'hC));
    step(1, 1);
    repeat (8) step(0, 1);
    chk("t4_pops", 64'(pop_count - p0), 64'd2);
    chk("t4_dones", 64'(done_count - d0), 64'd1);
    chk("t4_last_tag", 64'(o_done_tag), 64'd7);

    // Four commits before eligibility, then a commit colliding with a POP.
    d0 = done_count;
    for (int k = 0; k < 4; k++) push(mk(0, 1, 32'h600 + 32'(k * 4), 1, 5'(11 + k), $urandom, 4'hF));
    repeat (4) step(1, 1);
    chk("t5_cnt_four", 64'(dut.u_cnt.cnt_q), 64'd4);
    push(mk(1, 1, 32'h700, 1, 5'd15, 32'h77777777, 4'h1));
    foreach (sq[k]) sq[k].a = 1'b1;
    drive_head();
    did = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_re && !did && uncommitted > 0) begin
        did = 1;
        c_before = credit;
        step(1, 1);
        chk("t5_commit_pop_net_zero", 64'(dut.u_cnt.cnt_q), 64'(c_before));
      end else step(0, 1);
    end
    chk("t5_commit_pop_seen", 64'(did), 64'd1);
    chk("t5_dones", 64'(done_count - d0), 64'd5);
    chk("t5_queue_empty", 64'(sq.size()), 64'd0);

    // Reset during REQ.
    push(mk(1, 1, 32'h800, 1, 5'd10, 32'h88888888, 4'hF));
    for (int k = 0; k < 10 && !o_mreq; k++) step(k == 0, 0);
    chk("t6_in_req", 64'(o_mreq), 64'd1);
    mon_en = 0;
    #3 rst_n = 1'b0;
    #1 chk("t6_mreq_async_drop", 64'(o_mreq), 64'd0);
    sq.delete(); exp_req.delete(); exp_tag.delete();
    credit = 0; uncommitted = 0; do_pop = 0;
    drive_head();
    step(0, 0);
    step(0, 0);
    rst_n = 1'b1;
    chk("t6_cnt_after", 64'(dut.u_cnt.cnt_q), 64'd0);
    chk("t6_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    chk("t6_no_re", 64'(o_re), 64'd0);
    mon_en = 1;
    p0 = pop_count;
    push(mk(1, 1, 32'h900, 1, 5'd12, 32'h99999999, 4'h6));
    repeat (6) step(0, 1);
    chk("t6_no_pop_after_reset", 64'(pop_count), 64'(p0));

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      if (sq.size() < SZ && $urandom_range(0, 2) == 0) begin
        push(mk(1, $urandom_range(0, 4) != 0, $urandom, 1, tag_ctr, $urandom, 4'($urandom)));
        tag_ctr++;
      end
      step(uncommitted > 0 && $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end

    // Drain everything with bounded wait.
    begin
      int k;
      for (k = 0; k < 400; k++) begin
        if (sq.size() == 0 && !o_mreq && !o_re) break;
        step(uncommitted > 0, 1);
      end
      chk("drain_timeout", 64'(k < 400), 64'd1);
    end
    repeat (3) step(0, 1);
    chk("final_req_queue", 64'(exp_req.size()), 64'd0);
    chk("final_tag_queue", 64'(exp_tag.size()), 64'd0);
    chk("final_cnt", 64'(dut.u_cnt.cnt_q), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
